// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
// Holds the transmit FSM state encoding, the parity_mode codes and a small
// helper that says whether a parity bit is sent for a given mode.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    // Code 2'b11 is also "no parity"; only the two codes below enable it.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Down-counter reloaded with max(div,1)-1; tick is high during the last clk
// cycle of every bit period.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   restart : reload the counter now (start of a new frame)
//   div     : clk cycles per bit, 0 behaves as 1
//   tick    : last cycle of the current bit period
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    assign reload = (div == '0) ? '0 : div - DIV_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || (cnt == '0)) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter core: serialises one latched payload per frame as
// start, DATA_W data bits (LSB first), optional parity, one or two stops.
//   clk, reset   : system clock, asynchronous active-high reset
//   baud_div     : clk cycles per bit (0 behaves as 1)
//   parity_mode  : 00/11 none, 01 even, 10 odd
//   stop2        : 1 selects two stop bits
//   tx_data      : payload, taken when tx_valid && tx_ready
//   tx_ready     : high only while idle and out of reset
//   txd          : serial line, idle high
//   busy         : inverse of tx_ready
//   tx_done      : pulse in the final cycle of the last stop bit
//
// state     | meaning
// ST_IDLE   | line high, waiting for a transfer
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit, only when enabled by the latched mode
// ST_STOP   | one or two high stop bits
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state;
    logic              armed;
    logic [DATA_W-1:0] shift_q;
    logic [DIV_W-1:0]  div_q;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;
    logic              stop_idx;
    logic [BIT_W-1:0]  bit_idx;
    logic              txd_q;

    logic              transfer;
    logic              tick;
    logic [DIV_W-1:0]  tick_div;

    // armed keeps tx_ready low while reset is held and for no longer:
    // it sets on the first edge after release.
    assign tx_ready = (state == ST_IDLE) && armed;
    assign busy     = ~tx_ready;
    assign transfer = tx_valid && tx_ready;
    assign txd      = txd_q;
    assign tx_done  = (state == ST_STOP) && tick && (stop_idx == stop2_q);

    // The counter reloads on the transfer edge, before div_q holds the new
    // divisor, so the live input is used while idle.
    assign tick_div = (state == ST_IDLE) ? baud_div : div_q;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (transfer),
        .div     (tick_div),
        .tick    (tick)
    );

    // txd is registered and loaded with the value of the bit being entered,
    // so the line is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            shift_q   <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_idx  <= 1'b0;
            bit_idx   <= '0;
            txd_q     <= 1'b1;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (transfer) begin
                        shift_q   <= tx_data;
                        div_q     <= baud_div;
                        par_en_q  <= parity_enabled(parity_mode);
                        par_bit_q <= (^tx_data) ^ (parity_mode == PAR_ODD);
                        stop2_q   <= stop2;
                        stop_idx  <= 1'b0;
                        bit_idx   <= '0;
                        txd_q     <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        txd_q <= shift_q[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            txd_q   <= par_en_q ? par_bit_q : 1'b1;
                            state   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        txd_q <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    txd_q <= 1'b1;
                    if (tick) begin
                        if (stop_idx == stop2_q) begin
                            stop_idx <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    txd_q <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core (DATA_W=8, DIV_W=16).
// Outputs are sampled on the falling clock edge; cycle k of a frame is the
// k-th falling edge after the transfer edge.
module tb_uart_tx_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        busy;
    logic        tx_done;

    int checks   = 0;
    int failures = 0;

    logic cap_txd  [0:127];
    logic cap_done [0:127];
    logic cap_rdy  [0:127];

    uart_tx_core #(
        .DATA_W (8),
        .DIV_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .txd         (txd),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    // Offers one frame, then scrambles every input right after the transfer
    // (baud_div goes to div_after) and records ncyc+1 cycles of outputs.
    // Called and returns on a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic [15:0] div,
                              input logic [1:0] pm, input logic st2,
                              input logic [15:0] div_after, input int ncyc,
                              output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            else @(negedge clk);
        end
        tx_data     = d;
        baud_div    = div;
        parity_mode = pm;
        stop2       = st2;
        tx_valid    = 1'b1;
        @(negedge clk);
        tx_valid    = 1'b0;
        tx_data     = ~d;
        baud_div    = div_after;
        parity_mode = pm ^ 2'b11;
        stop2       = ~st2;
        for (int k = 1; k <= ncyc + 1; k++) begin
            cap_txd[k]  = txd;
            cap_done[k] = tx_done;
            cap_rdy[k]  = tx_ready;
            if (k <= ncyc) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; tx_valid = 1'b0; tx_data = '0;
        baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", tx_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL release_ready_early got=%b exp=0", tx_ready); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
    endtask

    // 0xA5, 8N1, 4 cycles/bit: 0,1,0,1,0,0,1,0,1,1 -> 40 cycles
    task automatic test_8n1();
        logic ok;
        logic e;
        logic [0:9] bits;
        bits = 10'b0_10100101_1;
        send_frame(8'hA5, 16'd4, 2'b00, 1'b0, 16'd4, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL 8n1_ready_wait got=timeout exp=ready"); end
        for (int k = 1; k <= 40; k++) begin
            e = bits[(k - 1) / 4];
            checks++; if (cap_txd[k] !== e) begin failures++; $display("FAIL 8n1_txd cyc=%0d got=%b exp=%b", k, cap_txd[k], e); end
            checks++; if (cap_done[k] !== (k == 40)) begin failures++; $display("FAIL 8n1_done cyc=%0d got=%b exp=%b", k, cap_done[k], k == 40); end
            checks++; if (cap_rdy[k] !== 1'b0) begin failures++; $display("FAIL 8n1_ready cyc=%0d got=%b exp=0", k, cap_rdy[k]); end
        end
        checks++; if (cap_rdy[41] !== 1'b1) begin failures++; $display("FAIL 8n1_ready_after got=%b exp=1", cap_rdy[41]); end
        checks++; if (cap_txd[41] !== 1'b1) begin failures++; $display("FAIL 8n1_idle_txd got=%b exp=1", cap_txd[41]); end
    endtask

    // 0xA5 has four ones: even parity bit 0, odd parity bit 1; 44 cycles
    task automatic test_parity();
        logic ok;
        logic e;
        logic [0:10] bits;
        for (int m = 0; m < 2; m++) begin
            bits = (m == 0) ? 11'b0_10100101_0_1 : 11'b0_10100101_1_1;
            send_frame(8'hA5, 16'd4, (m == 0) ? 2'b01 : 2'b10, 1'b0, 16'd4, 44, ok);
            checks++; if (!ok) begin failures++; $display("FAIL parity_ready_wait mode=%0d got=timeout exp=ready", m); end
            for (int k = 1; k <= 44; k++) begin
                e = bits[(k - 1) / 4];
                checks++; if (cap_txd[k] !== e) begin failures++; $display("FAIL parity_txd mode=%0d cyc=%0d got=%b exp=%b", m, k, cap_txd[k], e); end
                checks++; if (cap_done[k] !== (k == 44)) begin failures++; $display("FAIL parity_done mode=%0d cyc=%0d got=%b exp=%b", m, k, cap_done[k], k == 44); end
            end
            checks++; if (cap_rdy[45] !== 1'b1) begin failures++; $display("FAIL parity_ready_after mode=%0d got=%b exp=1", m, cap_rdy[45]); end
        end
    endtask

    // baud_div 0 behaves as 1; two stop bits -> 11-cycle frame
    task automatic test_div0_stop2();
        logic ok;
        logic e;
        logic [0:10] bits;
        bits = 11'b0_00000000_1_1;
        send_frame(8'h00, 16'd0, 2'b00, 1'b1, 16'd0, 11, ok);
        checks++; if (!ok) begin failures++; $display("FAIL div0_ready_wait got=timeout exp=ready"); end
        for (int k = 1; k <= 11; k++) begin
            e = bits[k - 1];
            checks++; if (cap_txd[k] !== e) begin failures++; $display("FAIL div0_txd cyc=%0d got=%b exp=%b", k, cap_txd[k], e); end
            checks++; if (cap_done[k] !== (k == 11)) begin failures++; $display("FAIL div0_done cyc=%0d got=%b exp=%b", k, cap_done[k], k == 11); end
        end
        checks++; if (cap_rdy[12] !== 1'b1) begin failures++; $display("FAIL div0_ready_after got=%b exp=1", cap_rdy[12]); end
    endtask

    // tx_valid held: 0x01 then 0x80 at 2 cycles/bit; frames at 1..20 and 22..41
    task automatic test_back_to_back();
        logic e;
        logic [0:9] f1;
        logic [0:9] f2;
        int waits;
        f1 = 10'b0_10000000_1;
        f2 = 10'b0_00000001_1;
        waits = 0;
        while (!tx_ready && waits < 100) begin @(negedge clk); waits++; end
        checks++; if (!tx_ready) begin failures++; $display("FAIL b2b_ready_wait got=%b exp=1", tx_ready); end
        tx_data = 8'h01; baud_div = 16'd2; parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h80;
        for (int k = 1; k <= 42; k++) begin
            cap_txd[k]  = txd;
            cap_done[k] = tx_done;
            cap_rdy[k]  = tx_ready;
            if (k == 22) tx_valid = 1'b0;
            if (k < 42) @(negedge clk);
        end
        for (int k = 1; k <= 42; k++) begin
            if (k <= 20)      e = f1[(k - 1) / 2];
            else if (k <= 21) e = 1'b1;
            else if (k <= 41) e = f2[(k - 22) / 2];
            else              e = 1'b1;
            checks++; if (cap_txd[k] !== e) begin failures++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", k, cap_txd[k], e); end
            checks++; if (cap_done[k] !== (k == 20 || k == 41)) begin failures++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, cap_done[k], k == 20 || k == 41); end
            checks++; if (cap_rdy[k] !== (k == 21 || k == 42)) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", k, cap_rdy[k], k == 21 || k == 42); end
        end
    endtask

    // divisor changes 4 -> 8 right after transfer; next frame (0x3C) uses 8
    task automatic test_div_change();
        logic ok;
        logic e;
        logic [0:9] bits;
        bits = 10'b0_10100101_1;
        send_frame(8'hA5, 16'd4, 2'b00, 1'b0, 16'd8, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL divchg_ready_wait1 got=timeout exp=ready"); end
        for (int k = 1; k <= 40; k++) begin
            e = bits[(k - 1) / 4];
            checks++; if (cap_txd[k] !== e) begin failures++; $display("FAIL divchg1_txd cyc=%0d got=%b exp=%b", k, cap_txd[k], e); end
            checks++; if (cap_done[k] !== (k == 40)) begin failures++; $display("FAIL divchg1_done cyc=%0d got=%b exp=%b", k, cap_done[k], k == 40); end
        end
        bits = 10'b0_00111100_1;
        send_frame(8'h3C, 16'd8, 2'b00, 1'b0, 16'd8, 80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL divchg_ready_wait2 got=timeout exp=ready"); end
        for (int k = 1; k <= 80; k++) begin
            e = bits[(k - 1) / 8];
            checks++; if (cap_txd[k] !== e) begin failures++; $display("FAIL divchg2_txd cyc=%0d got=%b exp=%b", k, cap_txd[k], e); end
            checks++; if (cap_done[k] !== (k == 80)) begin failures++; $display("FAIL divchg2_done cyc=%0d got=%b exp=%b", k, cap_done[k], k == 80); end
        end
        checks++; if (cap_rdy[81] !== 1'b1) begin failures++; $display("FAIL divchg2_ready_after got=%b exp=1", cap_rdy[81]); end
    endtask

    // reset during data bit 3 (frame cycles 17..20) of 0xA5 at 4 cycles/bit
    task automatic test_reset_abort();
        int waits;
        int bad_txd;
        int bad_done;
        waits = 0;
        while (!tx_ready && waits < 100) begin @(negedge clk); waits++; end
        tx_data = 8'hA5; baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 1; k < 18; k++) @(negedge clk);
        checks++; if (txd !== 1'b0) begin failures++; $display("FAIL abort_pre_txd got=%b exp=0", txd); end
        reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL abort_txd got=%b exp=1", txd); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", tx_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", tx_done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_release got=%b exp=1", tx_ready); end
        bad_txd = 0;
        bad_done = 0;
        for (int k = 0; k < 50; k++) begin
            if (txd !== 1'b1) bad_txd++;
            if (tx_done !== 1'b0) bad_done++;
            @(negedge clk);
        end
        checks++; if (bad_txd != 0) begin failures++; $display("FAIL abort_no_resume_txd got=%0d low cycles exp=0", bad_txd); end
        checks++; if (bad_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses exp=0", bad_done); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_div0_stop2();
        test_back_to_back();
        test_div_change();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, width of baud divisor input.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 baud_div  input  DIV_W  clk cycles per bit; value 0 treated as 1.
REQ-006 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-007 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-008 tx_data  input  DATA_W  frame payload.
REQ-009 tx_valid  input  1  payload offered.
REQ-010 tx_ready  output  1  core accepts payload this cycle.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  frame in progress.
REQ-013 tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; encodings from shared package.
REQ-015 SHALL assert tx_ready only in IDLE; transfer occurs when tx_valid and tx_ready are both high at a clock edge.
REQ-016 SHALL latch tx_data, baud_div, parity_mode, stop2 at transfer; input changes mid-frame SHALL NOT affect the current frame.
REQ-017 SHALL drive txd low starting the cycle after transfer (START), one-cycle latency.
REQ-018 SHALL hold every bit (start, data, parity, each stop) for exactly max(baud_div,1) clk cycles, timed by a counter reset at transfer.
REQ-019 SHALL send data bits LSB first, DATA_W bits, bit index counter wrapping to 0 on exit from DATA.
REQ-020 SHALL skip PARITY when parity_mode is 00 or 11; even parity bit = XOR of latched data; odd = its inverse.
REQ-021 SHALL drive txd high in STOP for one or two bit periods per latched stop2, and high in IDLE.
REQ-022 Frame length SHALL be baud_div*(1+DATA_W+P+S) cycles, P in {0,1}, S in {1,2}.
REQ-023 SHALL pulse tx_done during the final cycle of the last stop bit, then enter IDLE with tx_ready high the next cycle.
REQ-024 SHALL support back-to-back frames: transfer on the first tx_ready cycle yields START immediately after, one idle-high cycle between frames.
REQ-025 busy SHALL equal not tx_ready.
REQ-026 tx_valid held high without tx_ready SHALL be ignored; no buffering beyond the one latched frame.

Reset
REQ-027 On reset asserted, SHALL immediately force IDLE, txd=1, tx_ready=0, busy=1, tx_done=0, counters=0, regardless of frame in progress.
REQ-028 tx_ready SHALL rise the first clock edge after reset deasserts; aborted frame SHALL NOT resume.

Structure
REQ-029 Package uart_pkg SHALL hold state encoding typedef and parity_mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-030 Bit-period counter SHALL be sub-module uart_baud_tick (inputs clk, reset, restart, div; output tick), reusable by the receiver.

Verification
REQ-031 DATA_W=8, baud_div=4, 8N1, tx_data=0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles, tx_done at cycle 40.
REQ-032 Same, parity_mode=01 -> parity bit 0; parity_mode=10 -> parity bit 1; frame 44 cycles.
REQ-033 baud_div=0, stop2=1, tx_data=0x00 -> each bit 1 cycle, 11-cycle frame, two high stop bits.
REQ-034 tx_valid held high, payloads 0x01 then 0x80, baud_div=2 -> two frames, one idle cycle between, second accepted the cycle tx_ready rises.
REQ-035 reset asserted during data bit 3 -> txd=1 same cycle, tx_ready=1 first edge after release, no tx_done.
REQ-036 baud_div changed 4->8 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8.
